// File: rtl/adder_activity_monitor.sv
// -----------------------------------------------------------------------------
// adder_activity_monitor
//
// Two-stage pipelined WIDTH-bit adder with on-chip switching-activity counters.
// Every valid result {cout, sum} is compared with the previous valid result and
// the number of flipped bits is accumulated into a saturating toggle counter.
// A second saturating counter tracks the number of valid results.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      operands valid this cycle
//   a, b, cin     operands and carry in
//   clear         synchronous clear of counters, sat flag and previous-result snapshot
//   out_valid     sum/cout valid
//   sum, cout     registered result
//   toggle_count  saturating total of bit toggles on {cout, sum}
//   result_count  saturating count of valid results
//   sat           sticky flag: either counter has saturated
// -----------------------------------------------------------------------------
module adder_activity_monitor #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             clear,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] result_count,
    output logic             sat
);

    // Popcount of a (WIDTH+1)-bit vector needs enough bits to hold WIDTH+1.
    localparam int PW = $clog2(WIDTH + 2);
    // Toggle adder is wide enough that neither operand can overflow it.
    localparam int SW = ((CNT_W > PW) ? CNT_W : PW) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Stage 1 operand registers
    logic             v1;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;

    // Last valid {cout, sum}
    logic [WIDTH:0]   prev;

    logic [WIDTH:0]   res;
    logic [WIDTH:0]   diff;
    logic [PW-1:0]    pop;
    logic [SW-1:0]    tsum;
    logic             t_over;
    logic             r_full;

    always_comb begin
        res    = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff   = res ^ prev;
        pop    = '0;
        for (int i = 0; i <= WIDTH; i++) begin
            pop = pop + PW'(diff[i]);
        end
        tsum   = SW'(toggle_count) + SW'(pop);
        t_over = (tsum > SW'(CNT_MAX));
        r_full = (result_count == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1           <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            out_valid    <= 1'b0;
            sum          <= '0;
            cout         <= 1'b0;
            prev         <= '0;
            toggle_count <= '0;
            result_count <= '0;
            sat          <= 1'b0;
        end else begin
            // Stage 1
            v1 <= in_valid;
            if (in_valid) begin
                a_q   <= a;
                b_q   <= b;
                cin_q <= cin;
            end

            // Stage 2
            out_valid <= v1;
            if (v1) begin
                {cout, sum} <= res;
            end

            // Activity counters; clear beats a coincident load, but the
            // snapshot still tracks that result so the chain stays intact.
            if (clear) begin
                toggle_count <= '0;
                result_count <= '0;
                sat          <= 1'b0;
                prev         <= v1 ? res : '0;
            end else if (v1) begin
                prev         <= res;
                toggle_count <= t_over ? CNT_MAX : tsum[CNT_W-1:0];
                result_count <= r_full ? CNT_MAX : result_count + CNT_W'(1);
                if (t_over || r_full) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_activity_monitor.sv
// -----------------------------------------------------------------------------
// Testbench for adder_activity_monitor. Two instances: WIDTH=4/CNT_W=8 for the
// functional scenarios and WIDTH=4/CNT_W=3 for saturation. Stimulus pushes the
// hand-computed expected result into a per-instance queue; a monitor per
// instance pops and compares whenever out_valid is seen.
// -----------------------------------------------------------------------------
module tb_adder_activity_monitor;

    typedef struct {
        int s;
        int co;
        int tc;
        int rc;
        int st;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       in_valid8;
    logic       in_valid3;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       clear;

    logic       ov8, co8, sat8;
    logic [3:0] sum8;
    logic [7:0] tc8, rc8;

    logic       ov3, co3, sat3;
    logic [3:0] sum3;
    logic [2:0] tc3, rc3;

    int checks = 0;
    int errors = 0;

    exp_t q8[$];
    exp_t q3[$];

    adder_activity_monitor #(.WIDTH(4), .CNT_W(8)) dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid8),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .clear        (clear),
        .out_valid    (ov8),
        .sum          (sum8),
        .cout         (co8),
        .toggle_count (tc8),
        .result_count (rc8),
        .sat          (sat8)
    );

    adder_activity_monitor #(.WIDTH(4), .CNT_W(3)) dut3 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid3),
        .a            (a),
        .b            (b),
        .cin          (cin),
        .clear        (clear),
        .out_valid    (ov3),
        .sum          (sum3),
        .cout         (co3),
        .toggle_count (tc3),
        .result_count (rc3),
        .sat          (sat3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input int s, input int co, input int tc, input int rc,
                                input int st);
        exp_t e;
        e.s  = s;
        e.co = co;
        e.tc = tc;
        e.rc = rc;
        e.st = st;
        return e;
    endfunction

    // Drive one cycle of inputs (called at a negedge), advance to next negedge.
    task automatic step(input logic v8, input logic v3, input int av, input int bv,
                        input logic ci, input logic clr);
        in_valid8 = v8;
        in_valid3 = v3;
        a         = 4'(av);
        b         = 4'(bv);
        cin       = ci;
        clear     = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Monitors sample 1 time unit after the active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && ov8) begin
            if (q8.size() == 0) begin
                chk("dut8 unexpected out_valid", 1, 0);
            end else begin
                e = q8.pop_front();
                chk("dut8 sum", sum8, e.s);
                chk("dut8 cout", co8, e.co);
                chk("dut8 toggle_count", tc8, e.tc);
                chk("dut8 result_count", rc8, e.rc);
                chk("dut8 sat", sat8, e.st);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && ov3) begin
            if (q3.size() == 0) begin
                chk("dut3 unexpected out_valid", 1, 0);
            end else begin
                e = q3.pop_front();
                chk("dut3 sum", sum3, e.s);
                chk("dut3 cout", co3, e.co);
                chk("dut3 toggle_count", tc3, e.tc);
                chk("dut3 result_count", rc3, e.rc);
                chk("dut3 sat", sat3, e.st);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid8 = 1'b0;
        in_valid3 = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        clear     = 1'b0;
        #1;
        chk("reset out_valid", ov8, 0);
        chk("reset toggle_count", tc8, 0);
        chk("reset result_count", rc8, 0);
        chk("reset sat", sat8, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single op: 3+5 = 0_1000 against prev 0 -> 1 toggle
        q8.push_back(mk(8, 0, 1, 1, 0));
        step(1'b1, 1'b0, 3, 5, 1'b0, 1'b0);
        idle(3);

        // Clear with no load: counters back to zero, snapshot back to zero
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("clear toggle_count", tc8, 0);
        chk("clear result_count", rc8, 0);

        // Back-to-back with carry: 0_1000 then 1_0001 -> 1 + 3 toggles
        q8.push_back(mk(8, 0, 1, 1, 0));
        step(1'b1, 1'b0, 3, 5, 1'b0, 1'b0);
        q8.push_back(mk(1, 1, 4, 2, 0));
        step(1'b1, 1'b0, 15, 1, 1'b1, 1'b0);

        // Bubbles: counters hold
        idle(3);
        chk("idle toggle_count", tc8, 4);
        chk("idle result_count", rc8, 2);

        // Clear on the edge a zero result loads -> 0/0
        q8.push_back(mk(0, 0, 0, 0, 0));
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        // 1_1111 against 0 -> 5 toggles
        q8.push_back(mk(15, 1, 5, 1, 0));
        step(1'b1, 1'b0, 15, 15, 1'b1, 1'b0);
        // Clear collides with a 0_0001 load; snapshot must still take it, so an
        // identical follow-up result adds no toggles.
        q8.push_back(mk(1, 0, 0, 0, 0));
        step(1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
        q8.push_back(mk(1, 0, 0, 1, 0));
        step(1'b1, 1'b0, 1, 0, 1'b0, 1'b1);
        idle(2);

        // Reset mid-pipeline: operand captured, then reset between edges
        in_valid8 = 1'b1;
        a         = 4'd7;
        b         = 4'd7;
        cin       = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset out_valid", ov8, 0);
        chk("async reset sum", sum8, 0);
        chk("async reset cout", co8, 0);
        chk("async reset toggle_count", tc8, 0);
        chk("async reset result_count", rc8, 0);
        chk("async reset sat", sat8, 0);
        in_valid8 = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        idle(2);
        // First result after reset compares against 0
        q8.push_back(mk(1, 0, 1, 1, 0));
        step(1'b1, 1'b0, 1, 0, 1'b0, 1'b0);
        idle(2);

        // Saturation, CNT_W=3: alternate 1_1111 and 0_0000 (5 toggles each)
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) begin
                q3.push_back(mk(15, 1, (i == 0) ? 5 : 7, (i < 7) ? i + 1 : 7, (i >= 1) ? 1 : 0));
                step(1'b0, 1'b1, 15, 15, 1'b1, 1'b0);
            end else begin
                q3.push_back(mk(0, 0, 7, (i < 7) ? i + 1 : 7, 1));
                step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
            end
        end
        idle(3);
        chk("dut3 sat sticky", sat3, 1);
        chk("dut3 toggle_count held", tc3, 7);

        // Result counter alone saturating must raise sat
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("dut3 clear sat", sat3, 0);
        for (int i = 0; i < 8; i++) begin
            q3.push_back(mk(0, 0, 0, (i < 7) ? i + 1 : 7, (i == 7) ? 1 : 0));
            step(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
        end
        idle(3);

        chk("dut8 queue drained", q8.size(), 0);
        chk("dut3 queue drained", q3.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
